multi_channel_conversion_sequencer: RTL

Parametrised dual-slope conversion controller: the successor to the single-channel state machine and counter set. It sweeps up to NUM_CH analog front-end channels, runs a programmable input run-up, then times reference de-integration until the comparator crosses. Each signed, channel-tagged result is pushed into an internal first-word-fall-through FIFO. The block sits between the comparator/ready synchronisers and the SPI/debug readout logic.

---
 rtl/multi_channel_conversion_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_conversion_sequencer.sv
// Dual-slope conversion sequencer: sweeps masked AFE channels (settle, run-up, de-integrate) into a tagged-result FWFT FIFO.
// Control outputs registered; a result that meets a full FIFO without a same-cycle read is dropped and sets sticky overflow.
module multi_channel_conversion_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int CNT_W      = 12,
    parameter int RUNUP_W    = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  comp_i,
    input  logic                  analog_ready_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [NUM_CH-1:0]     ch_mask_i,
    input  logic [RUNUP_W-1:0]    runup_i,
    input  logic                  continuous_i,
    output logic [CH_W-1:0]       afe_sel_o,
    output logic [1:0]            phase_o,
    output logic                  ref_sign_o,
    output logic                  busy_o,
    output logic                  sweep_done_o,
    input  logic                  rd_en_i,
    output logic [CH_W+CNT_W+1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    input  logic                  clr_ovf_i,
    output logic                  irq_o
);
    localparam int DW = CH_W + CNT_W + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_INC  = CNT_W'(1);
    localparam logic [RUNUP_W-1:0] RUN_INC  = RUNUP_W'(1);
    localparam logic [AW:0]        PTR_INC  = (AW+1)'(1);

    typedef enum logic [2:0] {IDLE, SETTLE, RUNUP, DEINT, STORE, NEXT} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [RUNUP_W-1:0]  runup_q, runup_d, rcnt_q, rcnt_d;
    logic                cont_q, cont_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic                sign_q, sign_d, tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          phase_q, phase_d;
    logic                ref_q, ref_d, busy_q, busy_d, done_q, done_d;
    logic [CH_W-1:0]     start_ch, first_ch, higher_ch;
    logic                has_higher, push, pop, wr, drop;
    logic [AW:0]         wptr_q, rptr_q;
    logic [DW-1:0]       mem_q [FIFO_DEPTH];
    logic                ovf_q;

    // Lowest enabled channel (on the live and latched masks) and next enabled channel above the current one.
    always_comb begin
        start_ch   = '0;
        first_ch   = '0;
        higher_ch  = '0;
        has_higher = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) start_ch = CH_W'(i);
            if (mask_q[i])    first_ch = CH_W'(i);
            if (mask_q[i] && (CH_W'(i) > sel_q)) begin
                higher_ch  = CH_W'(i);
                has_higher = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            runup_q <= '0;
            rcnt_q  <= '0;
            cont_q  <= 1'b0;
            sel_q   <= '0;
            sign_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 2'b00;
            ref_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            runup_q <= runup_d;
            rcnt_q  <= rcnt_d;
            cont_q  <= cont_d;
            sel_q   <= sel_d;
            sign_q  <= sign_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            ref_q   <= ref_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        runup_d = runup_q;
        rcnt_d  = rcnt_q;
        cont_d  = cont_q;
        sel_d   = sel_q;
        sign_d  = sign_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (start_i && (|ch_mask_i)) begin
                state_d = SETTLE;
                mask_d  = ch_mask_i;
                runup_d = runup_i;
                cont_d  = continuous_i;
                sel_d   = start_ch;
            end
            SETTLE: if (analog_ready_i) begin
                state_d = RUNUP;
                rcnt_d  = '0;
            end
            // A zero run-up length still runs one cycle so the sign sample exists.
            RUNUP: if ((rcnt_q + RUN_INC) >= runup_q) begin
                state_d = DEINT;
                sign_d  = comp_i;
                cnt_d   = '0;
                tmo_d   = 1'b0;
            end else begin
                rcnt_d = rcnt_q + RUN_INC;
            end
            DEINT: if (comp_i != sign_q) begin
                state_d = STORE;
            end else if (cnt_q == CNT_LAST) begin
                state_d = STORE;
                cnt_d   = CNT_MAX;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_INC;
            end
            STORE: begin
                push    = 1'b1;
                state_d = NEXT;
            end
            NEXT: if (has_higher) begin
                sel_d   = higher_ch;
                state_d = SETTLE;
            end else if (cont_q) begin
                sel_d   = first_ch;
                state_d = SETTLE;
            end else begin
                sel_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            sel_d   = '0;
            push    = 1'b0;
        end
    end

    always_comb begin
        phase_d = 2'b00;
        if (state_d == RUNUP) phase_d = 2'b01;
        if (state_d == DEINT) phase_d = 2'b10;
        busy_d = (state_d != IDLE);
        done_d = (state_d == NEXT) && !has_higher;
        ref_d  = ref_q;
        if (state_d == IDLE)                             ref_d = 1'b0;
        else if (state_q == RUNUP && state_d == DEINT)   ref_d = ~comp_i;
    end

    assign pop  = rd_en_i && !empty_o;
    assign wr   = push && (!full_o || pop);
    assign drop = push && full_o && !pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr) begin
                mem_q[wptr_q[AW-1:0]] <= {sel_q, sign_q, tmo_q, cnt_q};
                wptr_q <= wptr_q + PTR_INC;
            end
            if (pop) rptr_q <= rptr_q + PTR_INC;
            if (drop)           ovf_q <= 1'b1;
            else if (clr_ovf_i) ovf_q <= 1'b0;
        end
    end

    assign afe_sel_o    = sel_q;
    assign phase_o      = phase_q;
    assign ref_sign_o   = ref_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = done_q;
    assign overflow_o   = ovf_q;
    assign empty_o      = (wptr_q == rptr_q);
    assign full_o       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign irq_o        = !empty_o;
    assign rd_data_o    = mem_q[rptr_q[AW-1:0]];
endmodule
